// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data Avalon-MM arbiter.
package avalon_bus_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_BE_W   = ARB_DATA_W / 8;

  localparam logic [ARB_DATA_W-1:0] ARB_ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INS_CMD,
    ST_INS_WAIT,
    ST_DATA_RD_CMD,
    ST_DATA_RD_WAIT,
    ST_DATA_WR_CMD
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INS  = 2'd1,
    OWN_DATA = 2'd2
  } arb_owner_t;

  // Which host owns the downstream port in a given state.
  function automatic arb_owner_t owner_of(input arb_state_t s);
    case (s)
      ST_INS_CMD, ST_INS_WAIT:                         return OWN_INS;
      ST_DATA_RD_CMD, ST_DATA_RD_WAIT, ST_DATA_WR_CMD: return OWN_DATA;
      default:                                         return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/avalon_bus_arbiter_watchdog_counter.sv
// Saturating cycle counter that flags when it has reached MAX (MAX=0 never expires).
module watchdog_counter #(
  parameter int unsigned MAX = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (MAX < 2) ? 1 : $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX);

  logic [CNT_W-1:0] count;

  // Count enabled cycles, holding at LIMIT; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (MAX != 0) && (count == LIMIT);

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM port between the fetch (read-only)
// host and the load/store host, one outstanding transaction at a time, with a
// watchdog that force-completes transactions the memory never finishes.
module avalon_bus_arbiter
  import avalon_bus_arbiter_pkg::*;
#(
  parameter int unsigned             TIMEOUT_CYCLES = 256,
  parameter logic [ARB_DATA_W-1:0]   ERR_DATA       = ARB_ERR_DATA
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch host
  input  logic [ARB_ADDR_W-1:0] ins_address,
  input  logic                  ins_read,
  input  logic [ARB_BE_W-1:0]   ins_byteenable,
  output logic [ARB_DATA_W-1:0] ins_agent_to_host,
  output logic                  ins_waitrequest,
  output logic                  ins_readdatavalid,
  // load/store host
  input  logic [ARB_ADDR_W-1:0] data_address,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ARB_BE_W-1:0]   data_byteenable,
  input  logic [ARB_DATA_W-1:0] data_host_to_agent,
  output logic [ARB_DATA_W-1:0] data_agent_to_host,
  output logic                  data_waitrequest,
  output logic                  data_readdatavalid,
  // shared memory port
  output logic [ARB_ADDR_W-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ARB_BE_W-1:0]   mem_byteenable,
  output logic [ARB_DATA_W-1:0] mem_host_to_agent,
  input  logic [ARB_DATA_W-1:0] mem_agent_to_host,
  input  logic                  mem_waitrequest,
  input  logic                  mem_readdatavalid,
  // status
  output logic                  timeout_err,
  output logic [1:0]            owner
);

  arb_state_t state, state_n, st_eff;
  arb_owner_t last_grant, last_n;
  logic       data_req;
  logic       wd_clear;
  logic       wd_en;
  logic       expired;

  assign data_req = data_read | data_write;

  // Timer restarts whenever the state changes and only runs inside CMD/WAIT states.
  assign wd_clear = (state_n != state) || (state == ST_IDLE);
  assign wd_en    = (state != ST_IDLE);

  watchdog_counter #(
    .MAX (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .en      (wd_en),
    .expired (expired)
  );

  // State and fairness pointer; ins wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_grant <= OWN_DATA;
    end else begin
      state      <= state_n;
      last_grant <= last_n;
    end
  end

  // Grant selection and transaction progress; expiry in CMD/WAIT returns to IDLE.
  always_comb begin
    state_n = state;
    last_n  = last_grant;
    case (state)
      ST_IDLE: begin
        if (ins_read && (!data_req || (last_grant == OWN_DATA))) begin
          state_n = ST_INS_CMD;
          last_n  = OWN_INS;
        end else if (data_req) begin
          state_n = data_write ? ST_DATA_WR_CMD : ST_DATA_RD_CMD;
          last_n  = OWN_DATA;
        end
      end
      ST_INS_CMD: begin
        if (expired)                           state_n = ST_IDLE;
        else if (ins_read && !mem_waitrequest) state_n = ST_INS_WAIT;
      end
      ST_DATA_RD_CMD: begin
        if (expired)                            state_n = ST_IDLE;
        else if (data_read && !mem_waitrequest) state_n = ST_DATA_RD_WAIT;
      end
      ST_DATA_WR_CMD: begin
        if (expired)                             state_n = ST_IDLE;
        else if (data_write && !mem_waitrequest) state_n = ST_IDLE;
      end
      ST_INS_WAIT, ST_DATA_RD_WAIT: begin
        if (mem_readdatavalid || expired) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Reset forces the idle view immediately so nothing leaks on the reset cycle.
  assign st_eff = rst ? state : ST_IDLE;
  assign owner  = owner_of(st_eff);

  // Route the owner's command downstream and the memory response back to the owner.
  always_comb begin
    mem_address        = '0;
    mem_read           = 1'b0;
    mem_write          = 1'b0;
    mem_byteenable     = '0;
    mem_host_to_agent  = '0;
    ins_agent_to_host  = '0;
    ins_waitrequest    = 1'b1;
    ins_readdatavalid  = 1'b0;
    data_agent_to_host = '0;
    data_waitrequest   = 1'b1;
    data_readdatavalid = 1'b0;
    timeout_err        = 1'b0;
    case (st_eff)
      ST_INS_CMD: begin
        mem_address     = ins_address;
        mem_byteenable  = ins_byteenable;
        mem_read        = ins_read && !expired;
        ins_waitrequest = expired ? 1'b0 : mem_waitrequest;
        timeout_err     = expired;
      end
      ST_INS_WAIT: begin
        ins_readdatavalid = mem_readdatavalid || expired;
        ins_agent_to_host = (expired && !mem_readdatavalid) ? ERR_DATA : mem_agent_to_host;
        timeout_err       = expired && !mem_readdatavalid;
      end
      ST_DATA_RD_CMD: begin
        mem_address       = data_address;
        mem_byteenable    = data_byteenable;
        mem_host_to_agent = data_host_to_agent;
        mem_read          = data_read && !expired;
        data_waitrequest  = expired ? 1'b0 : mem_waitrequest;
        timeout_err       = expired;
      end
      ST_DATA_WR_CMD: begin
        mem_address       = data_address;
        mem_byteenable    = data_byteenable;
        mem_host_to_agent = data_host_to_agent;
        mem_write         = data_write && !expired;
        data_waitrequest  = expired ? 1'b0 : mem_waitrequest;
        timeout_err       = expired;
      end
      ST_DATA_RD_WAIT: begin
        data_readdatavalid = mem_readdatavalid || expired;
        data_agent_to_host = (expired && !mem_readdatavalid) ? ERR_DATA : mem_agent_to_host;
        timeout_err        = expired && !mem_readdatavalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: arbitration vector table, directed corner
// sequences and a randomized two-host run against a transaction-level model.
module tb_avalon_bus_arbiter;

  localparam int unsigned TO = 16;
  localparam int NI = 24;
  localparam int ND = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins_address;
  logic        ins_read;
  logic [3:0]  ins_byteenable;
  logic [31:0] ins_agent_to_host;
  logic        ins_waitrequest;
  logic        ins_readdatavalid;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_byteenable;
  logic [31:0] data_host_to_agent;
  logic [31:0] data_agent_to_host;
  logic        data_waitrequest;
  logic        data_readdatavalid;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_host_to_agent;
  logic [31:0] mem_agent_to_host;
  logic        mem_waitrequest;
  logic        mem_readdatavalid;
  logic        timeout_err;
  logic [1:0]  owner;

  int n_cmp = 0;
  int n_fail = 0;

  avalon_bus_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .ERR_DATA       (32'hDEADBEEF)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ins_address        (ins_address),
    .ins_read           (ins_read),
    .ins_byteenable     (ins_byteenable),
    .ins_agent_to_host  (ins_agent_to_host),
    .ins_waitrequest    (ins_waitrequest),
    .ins_readdatavalid  (ins_readdatavalid),
    .data_address       (data_address),
    .data_read          (data_read),
    .data_write         (data_write),
    .data_byteenable    (data_byteenable),
    .data_host_to_agent (data_host_to_agent),
    .data_agent_to_host (data_agent_to_host),
    .data_waitrequest   (data_waitrequest),
    .data_readdatavalid (data_readdatavalid),
    .mem_address        (mem_address),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_byteenable     (mem_byteenable),
    .mem_host_to_agent  (mem_host_to_agent),
    .mem_agent_to_host  (mem_agent_to_host),
    .mem_waitrequest    (mem_waitrequest),
    .mem_readdatavalid  (mem_readdatavalid),
    .timeout_err        (timeout_err),
    .owner              (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled 2 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #2;
  endtask

  task automatic clear_inputs();
    ins_address = '0; ins_read = 1'b0; ins_byteenable = '0;
    data_address = '0; data_read = 1'b0; data_write = 1'b0;
    data_byteenable = '0; data_host_to_agent = '0;
    mem_agent_to_host = '0; mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0;
  endtask

  // Leaves the bench at the start of the first IDLE cycle after reset.
  task automatic do_reset();
    cyc();
    rst = 1'b0;
    clear_inputs();
    smp();
    check("rst_ins_wreq", ins_waitrequest, 1);
    check("rst_data_wreq", data_waitrequest, 1);
    check("rst_mem_strobes", {mem_read, mem_write}, 0);
    check("rst_rdv", {ins_readdatavalid, data_readdatavalid}, 0);
    check("rst_owner_err", {owner, timeout_err}, 0);
    cyc();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        ins_rd, d_rd, d_wr;
    logic [1:0]  own;
    logic        m_rd, m_wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        iw, dw;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } op_t;

  vec_t        vecs [8];
  op_t         ins_ops[$], data_ops[$], exp_cmds[$];
  logic [31:0] ins_exp[$], data_exp[$];
  logic [31:0] ref_mem [8];
  logic [31:0] resp_mem [8];

  function automatic logic [31:0] init_word(input int k);
    return 32'hA5A5_0000 + 32'(k * 32'h0101);
  endfunction

  initial begin
    int hi_cnt, leak, early, wr_cnt;
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);

    // ---- arbitration table: first grant after reset (ins wins ties) ----
    vecs[0] = '{0, 0, 0, 2'd0, 0, 0, 32'h0,    4'h0, 1, 1};
    vecs[1] = '{1, 0, 0, 2'd1, 1, 0, 32'h1000, 4'h3, 0, 1};
    vecs[2] = '{0, 1, 0, 2'd2, 1, 0, 32'h2000, 4'hC, 1, 0};
    vecs[3] = '{0, 0, 1, 2'd2, 0, 1, 32'h2000, 4'hC, 1, 0};
    vecs[4] = '{0, 1, 1, 2'd2, 0, 1, 32'h2000, 4'hC, 1, 0};
    vecs[5] = '{1, 1, 0, 2'd1, 1, 0, 32'h1000, 4'h3, 0, 1};
    vecs[6] = '{1, 0, 1, 2'd1, 1, 0, 32'h1000, 4'h3, 0, 1};
    vecs[7] = '{1, 1, 1, 2'd1, 1, 0, 32'h1000, 4'h3, 0, 1};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      ins_read = vecs[i].ins_rd; data_read = vecs[i].d_rd; data_write = vecs[i].d_wr;
      ins_address = 32'h1000; data_address = 32'h2000;
      ins_byteenable = 4'h3; data_byteenable = 4'hC;
      smp();
      check("tbl_idle_strobes", {mem_read, mem_write}, 0);
      cyc(); smp();
      check("tbl_owner", owner, vecs[i].own);
      check("tbl_mem_read", mem_read, vecs[i].m_rd);
      check("tbl_mem_write", mem_write, vecs[i].m_wr);
      check("tbl_mem_addr", mem_address, vecs[i].addr);
      check("tbl_mem_be", mem_byteenable, vecs[i].be);
      check("tbl_ins_wreq", ins_waitrequest, vecs[i].iw);
      check("tbl_data_wreq", data_waitrequest, vecs[i].dw);
    end

    // ---- 1: single fetch, response two cycles after accept ----
    do_reset();
    ins_read = 1; ins_address = 32'h40; ins_byteenable = 4'hF;
    smp();
    check("t1_idle_ins_wreq", ins_waitrequest, 1);
    cyc(); smp();
    check("t1_cmd_read", mem_read, 1);
    check("t1_cmd_addr", mem_address, 32'h40);
    check("t1_cmd_ins_wreq", ins_waitrequest, 0);
    check("t1_cmd_data_wreq", data_waitrequest, 1);
    cyc(); ins_read = 0; smp();
    check("t1_wait_no_rdv", ins_readdatavalid, 0);
    check("t1_wait_read_low", mem_read, 0);
    cyc(); mem_readdatavalid = 1; mem_agent_to_host = 32'h13; smp();
    check("t1_rdv", ins_readdatavalid, 1);
    check("t1_rdata", ins_agent_to_host, 32'h13);
    check("t1_data_no_rdv", data_readdatavalid, 0);
    check("t1_data_wreq", data_waitrequest, 1);
    cyc(); mem_readdatavalid = 0; smp();
    check("t1_release", owner, 0);

    // ---- 2: simultaneous fetch and store after reset ----
    do_reset();
    ins_read = 1; ins_address = 32'h80; ins_byteenable = 4'hF;
    data_write = 1; data_address = 32'h100; data_host_to_agent = 32'hCAFEF00D; data_byteenable = 4'hF;
    wr_cnt = 0;
    smp();
    cyc(); smp();
    check("t2_ins_first", owner, 1);
    check("t2_strobes", {mem_read, mem_write}, 2'b10);
    cyc(); ins_read = 0; mem_readdatavalid = 1; mem_agent_to_host = 32'h1111_1111; smp();
    check("t2_ins_rdata", ins_agent_to_host, 32'h1111_1111);
    check("t2_no_write_yet", mem_write, 0);
    cyc(); mem_readdatavalid = 0; smp();
    check("t2_idle_gap", {owner, mem_write}, 0);
    cyc(); smp();
    check("t2_write", mem_write, 1);
    check("t2_waddr", mem_address, 32'h100);
    check("t2_wdata", mem_host_to_agent, 32'hCAFEF00D);
    check("t2_data_wreq", data_waitrequest, 0);
    if (mem_write) wr_cnt++;
    for (int k = 0; k < 4; k++) begin
      cyc(); data_write = 0; smp();
      if (mem_write) wr_cnt++;
    end
    check("t2_write_once", wr_cnt, 1);

    // ---- 4: data read stalled 5 cycles while fetch waits ----
    do_reset();
    data_read = 1; data_address = 32'h200; data_byteenable = 4'hF; mem_waitrequest = 1;
    smp();
    cyc(); ins_read = 1; ins_address = 32'h44; ins_byteenable = 4'hF;
    hi_cnt = 0; leak = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      if (k == 5) mem_waitrequest = 0;
      smp();
      if (data_waitrequest) hi_cnt++;
      if (!ins_waitrequest) leak++;
    end
    check("t4_wreq_cycles", hi_cnt, 5);
    check("t4_accept", data_waitrequest, 0);
    cyc(); data_read = 0; mem_readdatavalid = 1; mem_agent_to_host = 32'hFF; smp();
    check("t4_rdv", data_readdatavalid, 1);
    check("t4_rdata", data_agent_to_host, 32'hFF);
    check("t4_ins_no_rdv", ins_readdatavalid, 0);
    if (!ins_waitrequest) leak++;
    cyc(); mem_readdatavalid = 0; smp();
    if (!ins_waitrequest) leak++;
    check("t4_ins_stalled", leak, 0);
    cyc(); smp();
    check("t4_ins_next", owner, 1);
    check("t4_ins_addr", mem_address, 32'h44);

    // ---- 5: fetch never answered -> timeout in WAIT, late response dropped ----
    do_reset();
    ins_read = 1; ins_address = 32'h48; ins_byteenable = 4'hF;
    smp();
    cyc(); smp();
    cyc(); ins_read = 0;
    early = 0;
    for (int k = 0; k < int'(TO); k++) begin
      smp();
      if (ins_readdatavalid || timeout_err) early++;
      cyc();
    end
    smp();
    check("t5_no_early", early, 0);
    check("t5_to_rdv", ins_readdatavalid, 1);
    check("t5_to_data", ins_agent_to_host, 32'hDEADBEEF);
    check("t5_to_err", timeout_err, 1);
    cyc(); mem_readdatavalid = 1; mem_agent_to_host = 32'h1234_5678; smp();
    check("t5_late_dropped", {ins_readdatavalid, data_readdatavalid}, 0);
    check("t5_err_once", timeout_err, 0);
    cyc(); mem_readdatavalid = 0;

    // ---- 5b: real data on the expiry cycle wins ----
    do_reset();
    ins_read = 1; ins_address = 32'h4C;
    smp();
    cyc();
    cyc(); ins_read = 0;
    for (int k = 0; k < int'(TO); k++) cyc();
    mem_readdatavalid = 1; mem_agent_to_host = 32'hABCD_0123; smp();
    check("t5b_rdata", ins_agent_to_host, 32'hABCD_0123);
    check("t5b_rdv", ins_readdatavalid, 1);
    check("t5b_no_err", timeout_err, 0);
    cyc(); mem_readdatavalid = 0;

    // ---- 5c: write stuck in CMD is dropped after the timeout ----
    do_reset();
    data_write = 1; data_address = 32'h300; data_host_to_agent = 32'h77; mem_waitrequest = 1;
    smp();
    cyc();
    early = 0;
    for (int k = 0; k < int'(TO); k++) begin
      smp();
      if (!data_waitrequest || timeout_err || !mem_write) early++;
      cyc();
    end
    smp();
    check("t5c_held", early, 0);
    check("t5c_cmd_dropped", mem_write, 0);
    check("t5c_release_host", data_waitrequest, 0);
    check("t5c_err", timeout_err, 1);
    cyc(); data_write = 0; smp();
    check("t5c_idle", {owner, timeout_err}, 0);

    // ---- 6: reset during DATA_RD_WAIT ----
    do_reset();
    data_read = 1; data_address = 32'h400;
    smp();
    cyc(); smp();
    check("t6_accept", data_waitrequest, 0);
    cyc(); data_read = 0; smp();
    check("t6_in_wait", owner, 2);
    cyc(); rst = 0; mem_readdatavalid = 1; mem_agent_to_host = 32'h55; smp();
    check("t6_rst_rdv", {ins_readdatavalid, data_readdatavalid}, 0);
    check("t6_rst_wreq", {ins_waitrequest, data_waitrequest}, 2'b11);
    check("t6_rst_strobes", {mem_read, mem_write}, 0);
    cyc(); rst = 1; smp();
    check("t6_after_idle", owner, 0);
    check("t6_after_rdv", {ins_readdatavalid, data_readdatavalid}, 0);
    cyc(); mem_readdatavalid = 0;

    run_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Both hosts keep a request pending, so the model grants strictly alternate
  // starting with ins, and each read returns the memory contents at that point.
  task automatic run_random();
    int          ii, di, cmd_idx, ins_got, data_got, n_to, stall_left, rdv_cnt;
    logic        turn_ins, ins_busy, ins_waiting, data_busy, data_waiting, rdv_pending;
    logic [31:0] rdv_data;
    op_t         op, ins_cur, data_cur, e;
    int          k;

    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = init_word(i);
      resp_mem[i] = init_word(i);
    end
    for (int i = 0; i < NI; i++)
      ins_ops.push_back('{1'b0, 32'h100 + 32'(4 * $urandom_range(0, 7)), 32'h0, 4'hF});
    for (int i = 0; i < ND; i++)
      data_ops.push_back('{1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 7)),
                           $urandom, 4'($urandom_range(1, 15))});

    ii = 0; di = 0; turn_ins = 1;
    while (ii < NI || di < ND) begin
      if (ii < NI && (turn_ins || di >= ND)) begin
        op = ins_ops[ii]; ii++; turn_ins = 0;
        ins_exp.push_back(ref_mem[op.addr[4:2]]);
      end else begin
        op = data_ops[di]; di++; turn_ins = 1;
        if (op.wr) ref_mem[op.addr[4:2]] = op.wdata;
        else       data_exp.push_back(ref_mem[op.addr[4:2]]);
      end
      exp_cmds.push_back(op);
    end

    do_reset();
    ii = 0; di = 0; cmd_idx = 0; ins_got = 0; data_got = 0; n_to = 0;
    ins_busy = 0; ins_waiting = 0; data_busy = 0; data_waiting = 0;
    rdv_pending = 0; rdv_cnt = 0; rdv_data = '0;
    stall_left = $urandom_range(0, 3);
    ins_cur = '{1'b0, 32'h0, 32'h0, 4'h0};
    data_cur = ins_cur;

    for (int c = 0; c < 4000; c++) begin
      if (c > 0) cyc();
      if (!ins_busy && !ins_waiting && ii < NI) begin
        ins_cur = ins_ops[ii]; ii++; ins_busy = 1;
      end
      if (!data_busy && !data_waiting && di < ND) begin
        data_cur = data_ops[di]; di++; data_busy = 1;
      end
      ins_read = ins_busy; ins_address = ins_cur.addr; ins_byteenable = ins_cur.be;
      data_read = data_busy && !data_cur.wr; data_write = data_busy && data_cur.wr;
      data_address = data_cur.addr; data_byteenable = data_cur.be;
      data_host_to_agent = data_busy ? data_cur.wdata : $urandom;
      mem_waitrequest = (stall_left != 0);
      if (rdv_pending && rdv_cnt == 0) begin
        mem_readdatavalid = 1; mem_agent_to_host = rdv_data; rdv_pending = 0;
      end else begin
        mem_readdatavalid = 0; mem_agent_to_host = $urandom;
        if (rdv_pending) rdv_cnt--;
      end
      smp();

      if (mem_read || mem_write) begin
        if (mem_waitrequest) stall_left--;
        else begin
          if (cmd_idx < exp_cmds.size()) begin
            e = exp_cmds[cmd_idx];
            check("rnd_cmd_kind", {mem_read, mem_write}, {~e.wr, e.wr});
            check("rnd_cmd_addr", mem_address, e.addr);
            check("rnd_cmd_be", mem_byteenable, e.be);
            if (e.wr) check("rnd_cmd_wdata", mem_host_to_agent, e.wdata);
          end else begin
            check("rnd_cmd_extra", cmd_idx, exp_cmds.size());
          end
          cmd_idx++;
          if (mem_write) resp_mem[mem_address[4:2]] = mem_host_to_agent;
          else begin
            rdv_pending = 1; rdv_cnt = $urandom_range(0, 3); rdv_data = resp_mem[mem_address[4:2]];
          end
          stall_left = $urandom_range(0, 3);
        end
      end
      if (ins_read && !ins_waitrequest) begin
        ins_busy = 0; ins_waiting = 1;
      end
      if ((data_read || data_write) && !data_waitrequest) begin
        data_busy = 0; data_waiting = !data_cur.wr;
      end
      if (ins_readdatavalid) begin
        check("rnd_ins_rdv_expected", ins_waiting, 1);
        k = ins_got;
        if (k < ins_exp.size()) check("rnd_ins_rdata", ins_agent_to_host, ins_exp[k]);
        ins_got++; ins_waiting = 0;
      end
      if (data_readdatavalid) begin
        check("rnd_data_rdv_expected", data_waiting, 1);
        k = data_got;
        if (k < data_exp.size()) check("rnd_data_rdata", data_agent_to_host, data_exp[k]);
        data_got++; data_waiting = 0;
      end
      if (timeout_err) n_to++;
      if (ii == NI && di == ND && !ins_busy && !ins_waiting && !data_busy && !data_waiting) break;
    end
    check("rnd_cmds_done", cmd_idx, exp_cmds.size());
    check("rnd_ins_reads", ins_got, ins_exp.size());
    check("rnd_data_reads", data_got, data_exp.size());
    check("rnd_no_timeouts", n_to, 0);
    cyc();
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired expected finished");
    $fatal(1);
  end

endmodule
